oam_dma_ctrl: RTL
=================

Name: oam_dma_ctrl

Overview:
- Sequences sprite OAM DMA, triggered by a CPU write to $4014.
- Halts the CPU through its RDY line and becomes bus master.
- Copies 256 bytes from CPU page {dma_page,00}..{dma_page,FF} into OAM by issuing writes to the PPU OAMDATA register, so the PPU register interface auto-increments OAMADDR.
- Sits between the CPU address decoder, the CPU bus mux and the PPU register interface; each clk is one CPU cycle.

Parameters:
- OAM_DATA_ADDR, 16'h2004, CPU bus address used for every DMA write.
- NUM_BYTES, 9'd256, bytes per transfer; must be 1..256.

Ports:
- clk  in  1  system clock; one CPU cycle per rising edge.
- reset  in  1  asynchronous, active-high reset.
- dma_wr  in  1  single-cycle strobe: CPU is writing $4014 this cycle.
- dma_page  in  8  CPU data bus value during the dma_wr cycle (source page).
- cpu_rw  in  1  1 = the CPU's current cycle is a read (halt may take effect).
- bus_data_in  in  8  CPU bus read data, valid by the end of a DMA read cycle.
- cpu_rdy  out  1  0 = CPU halted.
- bus_master  out  1  1 = DMA drives bus_addr/bus_rd/bus_wr/bus_data_out.
- bus_addr  out  16  DMA bus address.
- bus_rd  out  1  DMA read strobe.
- bus_wr  out  1  DMA write strobe.
- bus_data_out  out  8  DMA write data.
- dma_busy  out  1  transfer in progress (any state other than IDLE).

Behaviour:
- Parity: a 1-bit register cyc_odd, reset to 0, toggles every clk. cyc_odd=0 is a get (read) cycle; cyc_odd=1 is a put (write) cycle.
- Registers: state, page[7:0], idx[8:0], data_lat[7:0].
- Reset values: state=IDLE, page=0, idx=0, data_lat=0, cyc_odd=0.
- Outputs are Moore-decoded from state. In IDLE: cpu_rdy=1, bus_master=0, bus_rd=0, bus_wr=0, bus_addr=0, bus_data_out=0, dma_busy=0.
- IDLE:
  - dma_wr=1: latch page<=dma_page, idx<=0, go to HALT.
  - Otherwise stay.
- HALT (cpu_rdy=0, bus_master=0):
  - cpu_rw=1: the halt is taken. If cyc_odd=1 this cycle, go to READ; otherwise go to ALIGN.
  - cpu_rw=0: stay in HALT. The CPU is mid-write and ignores RDY; wait up to 3 consecutive write cycles.
- ALIGN (cpu_rdy=0, bus_master=1, no strobes): one dummy cycle, then go to READ.
- READ (cpu_rdy=0, bus_master=1, bus_rd=1, bus_addr={page,idx[7:0]}):
  - Capture data_lat<=bus_data_in on the closing edge, go to WRITE.
  - This state is always entered on a cycle with cyc_odd=0.
- WRITE (cpu_rdy=0, bus_master=1, bus_wr=1, bus_addr=OAM_DATA_ADDR, bus_data_out=data_lat):
  - idx<=idx+1.
  - If idx==NUM_BYTES-1, go to IDLE; else go to READ.
- Latency:
  - Starting from the dma_wr cycle T with cpu_rw=1 at T+1: cpu_rdy is low for cycles T+1 .. T+513 (halt on odd) or T+1 .. T+514 (halt on even).
  - cpu_rdy returns to 1 on the cycle after the last WRITE.
- Address arithmetic: idx is 9 bits to hold the terminal compare; only idx[7:0] drives the address. The page never increments; no carry into the high byte.
- dma_wr while dma_busy=1: ignored; page is not relatched.
- dma_wr in the same cycle the final WRITE returns to IDLE: ignored. A new transfer starts only from a dma_wr seen while in IDLE.
- Reset mid-transfer: asynchronous return to IDLE; cpu_rdy=1 and bus_master=0 immediately. The partial OAM contents are left as written.
- bus_data_in is sampled only in READ.

Test Plan:
- Even-aligned start: reset; at cycle 1 (cyc_odd=1 at HALT) pulse dma_wr with dma_page=8'h02, cpu_rw=1, source RAM $0200+i = i^8'hA5 -> exactly 513 cycles with cpu_rdy=0. 256 reads $0200..$02FF alternate with 256 writes to $2004 carrying 8'hA5, 8'hA4, ... in order.
- Odd-aligned start: same stimulus but dma_wr one cycle later -> one ALIGN cycle (bus_master=1, no strobes); total cpu_rdy=0 span = 514 cycles.
- Halt delay: cpu_rw=0 for 2 cycles after dma_wr -> state stays HALT for those 2 cycles, no bus strobes. Transfer then proceeds with the correct parity and span of 515 or 516 cycles.
- Re-trigger while busy: dma_wr with page 8'h07 at byte 100 of a page-8'h02 transfer -> no effect; all reads remain in $02xx; span unchanged.
- Reset mid-transfer: assert reset after write #50 -> same-cycle cpu_rdy=1, bus_master=0, dma_busy=0. A new dma_wr (page 8'h03) then performs a full transfer starting at $0300.
- Back-to-back: second dma_wr (page 8'h04) issued 1 cycle after cpu_rdy returns high -> second transfer reads $0400..$04FF; first transfer's final write is to $2004 with byte $02FF.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_ctrl
// Brief    : Sprite OAM DMA sequencer. A CPU write to $4014 halts the CPU
//            through RDY. The block then takes the bus and copies one source
//            page into OAM. It does this with alternating reads of the page
//            and writes to the PPU OAMDATA register.
// Revision : 1.0 - initial release
// ============================================================================
module oam_dma_ctrl #(
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter logic [8:0]  NUM_BYTES     = 9'd256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_wr,
  input  logic [7:0]  dma_page,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_data_in,
  output logic        cpu_rdy,
  output logic        bus_master,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [7:0]  bus_data_out,
  output logic        dma_busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  // The index is one bit wider than the address byte so that a full
  // 256-byte transfer can be compared against its last index.
  localparam logic [8:0] LAST_IDX = NUM_BYTES - 9'd1;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [8:0]  idx_q, idx_d;
  logic [7:0]  data_lat_q, data_lat_d;
  logic        cyc_odd_q, cyc_odd_d;

  // State, transfer context and CPU cycle parity registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      page_q     <= 8'h00;
      idx_q      <= 9'd0;
      data_lat_q <= 8'h00;
      cyc_odd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      idx_q      <= idx_d;
      data_lat_q <= data_lat_d;
      cyc_odd_q  <= cyc_odd_d;
    end
  end

  // Next-state logic: halt, optional alignment, then read/write pairs.
  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    idx_d      = idx_q;
    data_lat_d = data_lat_q;
    cyc_odd_d  = ~cyc_odd_q;
    case (state_q)
      ST_IDLE: begin
        if (dma_wr) begin
          page_d  = dma_page;
          idx_d   = 9'd0;
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        // A CPU write cycle ignores RDY, so wait for a read cycle.
        // The first read must land on a get (even) cycle. Halting on an
        // even cycle therefore costs one extra alignment cycle.
        if (cpu_rw) begin
          state_d = cyc_odd_q ? ST_READ : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        data_lat_d = bus_data_in;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        idx_d   = idx_q + 9'd1;
        state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_READ;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode; the bus is quiet and zeroed outside READ/WRITE.
  always_comb begin
    cpu_rdy      = 1'b1;
    bus_master   = 1'b0;
    bus_addr     = 16'h0000;
    bus_rd       = 1'b0;
    bus_wr       = 1'b0;
    bus_data_out = 8'h00;
    dma_busy     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        dma_busy = 1'b0;
      end
      ST_HALT: begin
        cpu_rdy = 1'b0;
      end
      ST_ALIGN: begin
        cpu_rdy    = 1'b0;
        bus_master = 1'b1;
      end
      ST_READ: begin
        cpu_rdy    = 1'b0;
        bus_master = 1'b1;
        bus_rd     = 1'b1;
        bus_addr   = {page_q, idx_q[7:0]};
      end
      ST_WRITE: begin
        cpu_rdy      = 1'b0;
        bus_master   = 1'b1;
        bus_wr       = 1'b1;
        bus_addr     = OAM_DATA_ADDR;
        bus_data_out = data_lat_q;
      end
      default: begin
        dma_busy = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
